// File: rtl/mem_deskew.sv
// Deskews a rhombus-shaped lane stream (lane k delayed k cycles) into a DIM x DIM
// row-aligned matrix, then serves registered one-row-per-cycle reads.
module mem_deskew #(
  parameter  int BITS_AB = 8,
  parameter  int DIM     = 8,
  localparam int ROWBITS = $clog2(DIM),
  localparam int CNTBITS = $clog2(2*DIM-1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              en,
  input  logic signed [DIM-1:0][BITS_AB-1:0] Cin,
  input  logic        [ROWBITS-1:0]          Rdrow,
  output logic signed [DIM-1:0][BITS_AB-1:0] Cout,
  output logic                              busy,
  output logic                              done
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  localparam logic [CNTBITS-1:0] LAST = CNTBITS'(2*DIM-2);

  state_t                        r_state;
  logic [CNTBITS-1:0]            r_cnt;
  logic [BITS_AB-1:0]            r_mem [DIM][DIM];
  logic [DIM-1:0][BITS_AB-1:0]   r_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cout  <= '0;
      for (int unsigned i = 0; i < DIM; i++)
        for (int unsigned j = 0; j < DIM; j++)
          r_mem[i][j] <= '0;
    end else begin
      for (int unsigned j = 0; j < DIM; j++)
        r_cout[j] <= r_mem[Rdrow][j];

      if (start) begin
        r_state <= S_CAPTURE;
        r_cnt   <= '0;
      end else if (r_state == S_CAPTURE && en) begin
        // Lane k lands in column cnt-k; lanes outside the rhombus match no column.
        for (int unsigned k = 0; k < DIM; k++)
          for (int unsigned j = 0; j < DIM; j++)
            if (32'(r_cnt) == k + j)
              r_mem[k][j] <= Cin[k];
        // cnt parks on the last diagonal instead of wrapping.
        if (r_cnt == LAST)
          r_state <= S_DONE;
        else
          r_cnt <= r_cnt + CNTBITS'(1);
      end
    end
  end

  assign Cout = r_cout;
  assign busy = (r_state == S_CAPTURE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_mem_deskew.sv
// Randomized scoreboard bench for mem_deskew: a lane-level reference model predicts
// every Cout row and busy/done per cycle; a monitor pops and compares at negedge.
module tb_mem_deskew;

  localparam int N = 8;

  logic                      clk = 0;
  logic                      rst, start, en;
  logic signed [N-1:0][7:0]  Cin;
  logic [2:0]                Rdrow;
  logic signed [N-1:0][7:0]  Cout;
  logic                      busy, done;

  mem_deskew #(.BITS_AB(8), .DIM(N)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .Cin(Cin),
    .Rdrow(Rdrow), .Cout(Cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edge_no;
    logic [63:0] row;
    bit          busy;
    bit          done;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  int   total = 0;
  int   bad = 0;

  // Reference model: matrix contents plus "capturing / done / enabled-cycle count".
  logic signed [7:0] mm  [N][N];
  logic signed [7:0] src [N][N];
  bit m_cap = 0, m_done = 0;
  int m_t = 0;

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  initial forever begin
    exp_t x;
    @(negedge clk);
    while (q.size() > 0 && q[0].edge_no <= edge_n) begin
      x = q.pop_front();
      total++;
      if (Cout !== x.row) begin
        bad++;
        $display("FAIL row edge=%0d Rdrow-read got=%h want=%h", x.edge_no, Cout, x.row);
      end
      total++;
      if (busy !== x.busy) begin
        bad++;
        $display("FAIL busy edge=%0d got=%b want=%b", x.edge_no, busy, x.busy);
      end
      total++;
      if (done !== x.done) begin
        bad++;
        $display("FAIL done edge=%0d got=%b want=%b", x.edge_no, done, x.done);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout q=%0d", q.size());
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [2:0] rdr();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic [63:0] skew(int t);
    logic [63:0] v;
    for (int k = 0; k < N; k++) begin
      int c = t - k;
      v[k*8 +: 8] = (c >= 0 && c < N) ? src[k][c] : 8'h5A;
    end
    return v;
  endfunction

  task automatic step(input bit rs, input bit st, input bit e,
                      input logic [63:0] cin, input logic [2:0] rd);
    exp_t x;
    rst = rs; start = st; en = e; Cin = cin; Rdrow = rd;
    for (int j = 0; j < N; j++)
      x.row[j*8 +: 8] = rs ? 8'h00 : mm[rd][j];
    if (rs) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) mm[r][c] = 0;
      m_cap = 0; m_done = 0; m_t = 0;
    end else if (st) begin
      m_cap = 1; m_done = 0; m_t = 0;
    end else if (m_cap && e) begin
      for (int k = 0; k < N; k++) begin
        int c = m_t - k;
        if (c >= 0 && c < N) mm[k][c] = cin[k*8 +: 8];
      end
      m_t++;
      if (m_t == 2*N-1) begin
        m_cap = 0; m_done = 1;
      end
    end
    x.edge_no = edge_n + 1;
    x.busy = m_cap;
    x.done = m_done;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic capture(input bit en_on_start, input int stall_mask);
    step(0, 1, en_on_start, rand64(), rdr());
    for (int t = 0; t < 2*N-1; t++) begin
      step(0, 0, 1, skew(t), rdr());
      if (stall_mask[t]) step(0, 0, 0, rand64(), rdr());
    end
  endtask

  task automatic readout();
    for (int r = 0; r < N; r++) step(0, 0, 1'($urandom), rand64(), 3'(r));
    step(0, 0, 0, rand64(), rdr());
  endtask

  task automatic set_ramp(input int sgn);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) src[r][c] = 8'(sgn * (r*8 + c - 32));
  endtask

  task automatic set_rand();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) src[r][c] = 8'($urandom);
  endtask

  initial begin
    rst = 1; start = 0; en = 0; Cin = '0; Rdrow = '0;
    @(posedge clk); #1;

    // Reset with random noise on the other inputs, then read all rows.
    step(1, 1'($urandom), 1'($urandom), rand64(), rdr());
    step(1, 1'($urandom), 1'($urandom), rand64(), rdr());
    readout();

    // Full capture of the ramp matrix.
    set_ramp(1);
    capture(0, 0);
    readout();

    // Stalls after enabled cycles 2, 7 and 14.
    capture(0, (1 << 1) | (1 << 6) | (1 << 13));
    readout();

    // Restart mid-capture: start with en=1 must ignore its Cin.
    set_rand();
    step(0, 1, 0, rand64(), rdr());
    for (int t = 0; t < 6; t++) step(0, 0, 1, skew(t), rdr());
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) src[r][c] = -src[r][c];
    capture(1, 0);
    readout();

    // Reset mid-capture, then en without start writes nothing.
    set_rand();
    step(0, 1, 0, rand64(), rdr());
    for (int t = 0; t < 9; t++) step(0, 0, 1, skew(t), rdr());
    step(1, 0, 1, rand64(), rdr());
    for (int i = 0; i < 5; i++) step(0, 0, 1, rand64(), rdr());
    readout();

    // Signed extremes, then recapture of all -1.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) src[r][c] = ((r + c) % 2) ? 8'sh7F : 8'sh80;
    capture(0, 0);
    readout();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) src[r][c] = 8'shFF;
    capture(0, 0);
    readout();

    // Randomized captures with random stalls and start-cycle en.
    for (int n = 0; n < 6; n++) begin
      set_rand();
      capture(1'($urandom), int'($urandom_range(0, 32767)) & int'($urandom));
      readout();
    end

    step(0, 0, 0, rand64(), rdr());
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
